mult_unit: RTL and testbench

- Iterative multi-cycle multiplier that consumes the execute-stage start_mult request raised to the hazard logic.
- Owns the architectural HI/LO registers.
- Returns mult_busy, which the hazard logic uses to stall or flush the front of the pipeline, and serves MFHI/MFLO reads.
- Sits beside the execute-stage ALU; operands are the forwarded srcaE/srcbE values.

---
 rtl/mult_unit_pkg.sv | 14 +
 rtl/mult_datapath.sv | 65 ++++++
 rtl/mult_unit.sv | 116 +++++++++++
 tb/tb_mult_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_unit_pkg.sv
// Shared types and constants for the iterative multiplier.
// FSM state encoding and default counter sizing.
package mult_unit_pkg;

  localparam int MULT_WIDTH = 32;
  localparam int CW = $clog2(MULT_WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    FINISH = 2'b10
  } state_e;

endpackage

// File: rtl/mult_datapath.sv
// Shift-add datapath: operand magnitudes, accumulator,
// and the final sign correction of the product.
module mult_datapath #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [CNTW-1:0]    cnt_i,
  output logic [2*WIDTH-1:0] product_o
);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic               a_neg, b_neg;
  logic [2*WIDTH-1:0] addend;

  // Capture magnitudes on load, then one shift-add step per cycle.
  // A WIDTH-bit unsigned magnitude holds 2^(WIDTH-1) without overflow.
  always_comb begin
    a_neg    = signed_i & a_i[WIDTH-1];
    b_neg    = signed_i & b_i[WIDTH-1];
    addend   = {{WIDTH{1'b0}}, mcand_q} << cnt_i;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    if (load_i) begin
      mcand_d  = a_neg ? -a_i : a_i;
      mplier_d = b_neg ? -b_i : b_i;
      acc_d    = '0;
      neg_d    = a_neg ^ b_neg;
    end else if (step_i) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + addend;
      end
      mplier_d = mplier_q >> 1;
    end
  end

  // Datapath registers, cleared by synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
    end
  end

  assign product_o = neg_q ? -acc_q : acc_q;

endmodule

// File: rtl/mult_unit.sv
// Multi-cycle MULT/MULTU unit owning the HI/LO registers.
// Busy is a registered stall toward the hazard logic.
module mult_unit
  import mult_unit_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             signed_mult,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             mult_busy,
  output logic             mult_done
);

  localparam int CNTW = $clog2(WIDTH);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               load, step;
  logic [2*WIDTH-1:0] product;

  mult_datapath #(
    .WIDTH (WIDTH),
    .CNTW  (CNTW)
  ) u_dp (
    .clk       (clk),
    .reset     (reset),
    .load_i    (load),
    .step_i    (step),
    .signed_i  (signed_mult),
    .a_i       (srcaE),
    .b_i       (srcbE),
    .cnt_i     (cnt_q),
    .product_o (product)
  );

  // Next-state, HI/LO moves, and product writeback.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mthi) begin
          hi_d = srcaE;
        end
        if (mtlo) begin
          lo_d = srcaE;
        end
        if (start_mult) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        step  = 1'b1;
        cnt_d = cnt_q + CNTW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        hi_d    = product[2*WIDTH-1:WIDTH];
        lo_d    = product[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Control and architectural HI/LO registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign mult_busy = busy_q;
  assign mult_done = done_q;

endmodule

// File: tb/tb_mult_unit.sv
// Randomized self-checking bench for mult_unit.
// Reference products come from plain 64-bit arithmetic.
module tb_mult_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start_mult = 1'b0;
  logic         signed_mult = 1'b0;
  logic         mthi = 1'b0;
  logic         mtlo = 1'b0;
  logic [W-1:0] srcaE = '0;
  logic [W-1:0] srcbE = '0;
  logic [W-1:0] hi, lo;
  logic         mult_busy, mult_done;

  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] hi_m = '0;
  logic [W-1:0] lo_m = '0;

  always #5 clk = ~clk;

  mult_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_mult  (start_mult),
    .signed_mult (signed_mult),
    .srcaE       (srcaE),
    .srcbE       (srcbE),
    .mthi        (mthi),
    .mtlo        (mtlo),
    .hi          (hi),
    .lo          (lo),
    .mult_busy   (mult_busy),
    .mult_done   (mult_done)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("idle_busy", 64'(mult_busy), 64'(0));
      chk("idle_done", 64'(mult_done), 64'(0));
      chk("idle_hi", 64'(hi), 64'(hi_m));
      chk("idle_lo", 64'(lo), 64'(lo_m));
    end
  endtask

  task automatic move(input logic to_hi, input logic [W-1:0] v);
    mthi  = to_hi;
    mtlo  = ~to_hi;
    srcaE = v;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    if (to_hi) hi_m = v;
    else lo_m = v;
    chk("mv_hi", 64'(hi), 64'(hi_m));
    chk("mv_lo", 64'(lo), 64'(lo_m));
  endtask

  // inj: 0 none, 1 reissue start at busy cycle 10, 2 mthi while busy.
  // Starts at the current negedge; ends at the negedge showing done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sgn, input int inj, input logic mv);
    logic [63:0] ae, be, p;
    int cyc, dcnt;
    ae = sgn ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    be = sgn ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    p  = ae * be;
    start_mult  = 1'b1;
    signed_mult = sgn;
    srcaE       = a;
    srcbE       = b;
    mtlo        = mv;
    @(negedge clk);
    start_mult  = 1'b0;
    mtlo        = 1'b0;
    srcaE       = $urandom;
    srcbE       = $urandom;
    signed_mult = 1'($urandom);
    if (mv) lo_m = a;
    chk("busy_rise", 64'(mult_busy), 64'(1));
    cyc  = 0;
    dcnt = 0;
    while (mult_busy === 1'b1 && cyc < 100) begin
      if (mult_done === 1'b1) dcnt++;
      chk("hold_hi", 64'(hi), 64'(hi_m));
      chk("hold_lo", 64'(lo), 64'(lo_m));
      if (cyc == 10 && inj == 1) begin
        start_mult  = 1'b1;
        srcaE       = ~a;
        srcbE       = b ^ 32'h5a5a_5a5a;
        signed_mult = ~sgn;
      end
      if (cyc == 10 && inj == 2) begin
        mthi  = 1'b1;
        srcaE = 32'h0000_1234;
      end
      @(negedge clk);
      start_mult = 1'b0;
      mthi       = 1'b0;
      cyc++;
    end
    chk("busy_len", 64'(cyc), 64'(W + 1));
    chk("early_done", 64'(dcnt), 64'(0));
    chk("done", 64'(mult_done), 64'(1));
    hi_m = p[63:32];
    lo_m = p[31:0];
    chk("res_hi", 64'(hi), 64'(hi_m));
    chk("res_lo", 64'(lo), 64'(lo_m));
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h7FFF_FFFF;
      4: v = 32'($urandom_range(0, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    chk("rst_busy", 64'(mult_busy), 64'(0));
    chk("rst_done", 64'(mult_done), 64'(0));
    reset = 1'b1;
    @(negedge clk);

    move(1'b1, 32'h0000_1234);
    chk("mv_hi_const", 64'(hi), 64'h1234);
    move(1'b0, 32'hCAFE_0001);

    // Reset in the middle of a 7*9 operation.
    start_mult  = 1'b1;
    signed_mult = 1'b0;
    srcaE       = 32'd7;
    srcbE       = 32'd9;
    @(negedge clk);
    start_mult = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy", 64'(mult_busy), 64'(1));
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    hi_m = '0;
    lo_m = '0;
    chk("abort_hi", 64'(hi), 64'(0));
    chk("abort_lo", 64'(lo), 64'(0));
    chk("abort_busy", 64'(mult_busy), 64'(0));
    idle(40);

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
    chk("u_max_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("u_max_lo", 64'(lo), 64'h0000_0001);
    idle(1);

    run_op(-32'sd3, 32'd5, 1'b1, 0, 1'b0);
    chk("s_neg_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("s_neg_lo", 64'(lo), 64'hFFFF_FFF1);
    idle(2);

    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, 1'b0);
    chk("s_min_hi", 64'(hi), 64'h4000_0000);
    chk("s_min_lo", 64'(lo), 64'h0000_0000);
    idle(1);

    run_op(32'h0001_2345, 32'h0000_0777, 1'b0, 1, 1'b0);
    idle(1);

    run_op(32'hDEAD_BEEF, 32'h0000_0010, 1'b1, 2, 1'b0);
    idle(1);
    move(1'b1, 32'h0000_1234);

    run_op(32'h0000_0000, 32'h1357_9BDF, 1'b1, 0, 1'b0);
    run_op(32'h0000_0011, 32'hFFFF_FFFE, 1'b1, 0, 1'b1);
    idle(1);

    for (int i = 0; i < 25; i++) begin
      run_op(pick(), pick(), 1'($urandom), 0, 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) != 0) idle(1 + $urandom_range(0, 2));
    end
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
